// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the I/D memory port arbiter: FSM encoding, port IDs
// and the two-requester round-robin pick.
package mem_port_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  // On a tie the port that did not win last time goes next.
  function automatic logic pick_port(input logic i_req, input logic d_req,
                                     input logic last_grant);
    if (i_req && d_req) return ~last_grant;
    else if (d_req)     return PORT_D;
    else                return PORT_I;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the I-fetch and load/store ports:
// one transaction in flight, round-robin grant, response routed to its issuer.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int CORE         = 0,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    i_read,
  input  logic [ADDRESS_BITS-1:0] i_address,
  output logic                    i_ready,
  output logic                    i_valid,
  output logic [DATA_WIDTH-1:0]   i_out_data,
  output logic [ADDRESS_BITS-1:0] i_out_addr,
  input  logic                    d_read,
  input  logic                    d_write,
  input  logic [ADDRESS_BITS-1:0] d_address,
  input  logic [DATA_WIDTH-1:0]   d_in_data,
  output logic                    d_ready,
  output logic                    d_valid,
  output logic [DATA_WIDTH-1:0]   d_out_data,
  output logic [ADDRESS_BITS-1:0] d_out_addr,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [ADDRESS_BITS-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]   mem_in_data,
  input  logic                    mem_ready,
  input  logic                    mem_valid,
  input  logic [DATA_WIDTH-1:0]   mem_out_data,
  input  logic [ADDRESS_BITS-1:0] mem_out_addr,
  input  logic                    report
);

  logic [1:0]              state_q, state_d;
  // last_grant_q doubles as the owner of the transaction in flight.
  logic                    last_grant_q, last_grant_d;
  logic                    cap_write_q, cap_write_d;
  logic [ADDRESS_BITS-1:0] cap_addr_q, cap_addr_d;
  logic [DATA_WIDTH-1:0]   cap_data_q, cap_data_d;
  logic                    i_valid_q, i_valid_d;
  logic [DATA_WIDTH-1:0]   i_out_data_q, i_out_data_d;
  logic [ADDRESS_BITS-1:0] i_out_addr_q, i_out_addr_d;
  logic                    d_valid_q, d_valid_d;
  logic [DATA_WIDTH-1:0]   d_out_data_q, d_out_data_d;
  logic [ADDRESS_BITS-1:0] d_out_addr_q, d_out_addr_d;

  logic i_req, d_req, grant, grant_port, resp;

  // The report hook has no synthesizable effect.
  logic unused_report;
  assign unused_report = report ^ (CORE != 0);

  assign i_req      = i_read;
  assign d_req      = d_read | d_write;
  assign grant      = (state_q == ST_IDLE) && mem_ready && (i_req || d_req) && !reset;
  assign grant_port = pick_port(i_req, d_req, last_grant_q);
  assign resp       = (state_q == ST_WAIT) && mem_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= PORT_D;
      cap_write_q  <= 1'b0;
      cap_addr_q   <= '0;
      cap_data_q   <= '0;
      i_valid_q    <= 1'b0;
      i_out_data_q <= '0;
      i_out_addr_q <= '0;
      d_valid_q    <= 1'b0;
      d_out_data_q <= '0;
      d_out_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cap_write_q  <= cap_write_d;
      cap_addr_q   <= cap_addr_d;
      cap_data_q   <= cap_data_d;
      i_valid_q    <= i_valid_d;
      i_out_data_q <= i_out_data_d;
      i_out_addr_q <= i_out_addr_d;
      d_valid_q    <= d_valid_d;
      d_out_data_q <= d_out_data_d;
      d_out_addr_q <= d_out_addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (grant) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (mem_valid) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    last_grant_d = last_grant_q;
    cap_write_d  = cap_write_q;
    cap_addr_d   = cap_addr_q;
    cap_data_d   = cap_data_q;
    if (grant) begin
      last_grant_d = grant_port;
      if (grant_port == PORT_D) begin
        cap_write_d = d_write;
        cap_addr_d  = d_address;
        cap_data_d  = d_in_data;
      end else begin
        cap_write_d = 1'b0;
        cap_addr_d  = i_address;
      end
    end
  end

  always_comb begin
    i_valid_d    = resp && (last_grant_q == PORT_I);
    d_valid_d    = resp && (last_grant_q == PORT_D);
    i_out_data_d = i_out_data_q;
    i_out_addr_d = i_out_addr_q;
    d_out_data_d = d_out_data_q;
    d_out_addr_d = d_out_addr_q;
    if (i_valid_d) begin
      i_out_data_d = mem_out_data;
      i_out_addr_d = mem_out_addr;
    end
    if (d_valid_d) begin
      d_out_data_d = mem_out_data;
      d_out_addr_d = mem_out_addr;
    end
  end

  always_comb begin
    i_ready     = grant && (grant_port == PORT_I);
    d_ready     = grant && (grant_port == PORT_D);
    mem_read    = (state_q == ST_ISSUE) && !cap_write_q;
    mem_write   = (state_q == ST_ISSUE) && cap_write_q;
    mem_address = cap_addr_q;
    mem_in_data = cap_data_q;
  end

  assign i_valid    = i_valid_q;
  assign i_out_data = i_out_data_q;
  assign i_out_addr = i_out_addr_q;
  assign d_valid    = d_valid_q;
  assign d_out_data = d_out_data_q;
  assign d_out_addr = d_out_addr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, single fetch, write, contention,
// backpressure, stray responses and reset during an outstanding transaction.
module tb_mem_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 20;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          i_read = 1'b0;
  logic [AW-1:0] i_address = '0;
  logic          i_ready, i_valid;
  logic [DW-1:0] i_out_data;
  logic [AW-1:0] i_out_addr;
  logic          d_read = 1'b0, d_write = 1'b0;
  logic [AW-1:0] d_address = '0;
  logic [DW-1:0] d_in_data = '0;
  logic          d_ready, d_valid;
  logic [DW-1:0] d_out_data;
  logic [AW-1:0] d_out_addr;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_in_data;
  logic          mem_ready = 1'b0, mem_valid = 1'b0;
  logic [DW-1:0] mem_out_data = '0;
  logic [AW-1:0] mem_out_addr = '0;
  logic          report = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  mem_port_arbiter #(.CORE(0), .DATA_WIDTH(DW), .ADDRESS_BITS(AW)) dut (
    .clock(clock), .reset(reset),
    .i_read(i_read), .i_address(i_address), .i_ready(i_ready), .i_valid(i_valid),
    .i_out_data(i_out_data), .i_out_addr(i_out_addr),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_in_data(d_in_data),
    .d_ready(d_ready), .d_valid(d_valid), .d_out_data(d_out_data), .d_out_addr(d_out_addr),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_in_data(mem_in_data), .mem_ready(mem_ready), .mem_valid(mem_valid),
    .mem_out_data(mem_out_data), .mem_out_addr(mem_out_addr), .report(report)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    vectors++; if ({i_ready, i_valid, d_ready, d_valid, mem_read, mem_write} !== 6'b0) begin miscompares++; $display("FAIL reset_strobes: got %b want 000000", {i_ready, i_valid, d_ready, d_valid, mem_read, mem_write}); end
    vectors++; if ({mem_address, mem_in_data} !== '0) begin miscompares++; $display("FAIL reset_mem_bus: got %h/%h want 0/0", mem_address, mem_in_data); end
    vectors++; if ({i_out_data, i_out_addr, d_out_data, d_out_addr} !== '0) begin miscompares++; $display("FAIL reset_port_bus: got %h %h %h %h want all 0", i_out_data, i_out_addr, d_out_data, d_out_addr); end
    mem_ready = 1'b1; i_read = 1'b1; d_read = 1'b1; i_address = 20'h00004; d_address = 20'h00008;
    #1;
    vectors++; if ({i_ready, d_ready} !== 2'b10) begin miscompares++; $display("FAIL reset_first_tie: got i/d ready %b want 10", {i_ready, d_ready}); end
    tick();
    i_read = 1'b0; d_read = 1'b0;
    vectors++; if (mem_read !== 1'b1 || mem_address !== 20'h00004) begin miscompares++; $display("FAIL reset_first_issue: got rd=%b addr=%h want rd=1 addr=00004", mem_read, mem_address); end
    tick();
    mem_valid = 1'b1; mem_out_data = 32'h11111111; mem_out_addr = 20'h00004;
    tick();
    mem_valid = 1'b0;
    vectors++; if (i_valid !== 1'b1 || d_valid !== 1'b0) begin miscompares++; $display("FAIL reset_first_resp: got i/d valid %b%b want 10", i_valid, d_valid); end
  endtask

  task automatic test_ifetch();
    i_read = 1'b1; i_address = 20'h00010;
    #1;
    vectors++; if (i_ready !== 1'b1) begin miscompares++; $display("FAIL ifetch_ready: got %b want 1", i_ready); end
    tick();
    i_read = 1'b0;
    vectors++; if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== 20'h00010) begin miscompares++; $display("FAIL ifetch_issue: got rd=%b wr=%b addr=%h want 1 0 00010", mem_read, mem_write, mem_address); end
    tick();
    vectors++; if (mem_read !== 1'b0 || i_ready !== 1'b0) begin miscompares++; $display("FAIL ifetch_wait: got rd=%b ready=%b want 0 0", mem_read, i_ready); end
    mem_valid = 1'b1; mem_out_data = 32'h00000013; mem_out_addr = 20'h00010;
    tick();
    mem_valid = 1'b0;
    vectors++; if (i_valid !== 1'b1 || d_valid !== 1'b0) begin miscompares++; $display("FAIL ifetch_valid: got i/d valid %b%b want 10", i_valid, d_valid); end
    vectors++; if (i_out_data !== 32'h00000013 || i_out_addr !== 20'h00010) begin miscompares++; $display("FAIL ifetch_data: got %h@%h want 00000013@00010", i_out_data, i_out_addr); end
    tick();
    vectors++; if (i_valid !== 1'b0) begin miscompares++; $display("FAIL ifetch_pulse: got i_valid %b want 0", i_valid); end
  endtask

  task automatic test_dwrite();
    d_write = 1'b1; d_read = 1'b1; d_address = 20'h00100; d_in_data = 32'hDEADBEEF;
    #1;
    vectors++; if ({i_ready, d_ready} !== 2'b01) begin miscompares++; $display("FAIL dwrite_ready: got i/d ready %b want 01", {i_ready, d_ready}); end
    tick();
    d_write = 1'b0; d_read = 1'b0; d_in_data = 32'h0;
    vectors++; if (mem_write !== 1'b1 || mem_read !== 1'b0) begin miscompares++; $display("FAIL dwrite_strobe: got wr=%b rd=%b want 1 0", mem_write, mem_read); end
    vectors++; if (mem_in_data !== 32'hDEADBEEF || mem_address !== 20'h00100) begin miscompares++; $display("FAIL dwrite_bus: got %h@%h want deadbeef@00100", mem_in_data, mem_address); end
    tick();
    mem_valid = 1'b1; mem_out_data = 32'h0; mem_out_addr = 20'h00100;
    tick();
    mem_valid = 1'b0;
    vectors++; if (d_valid !== 1'b1 || i_valid !== 1'b0) begin miscompares++; $display("FAIL dwrite_ack: got d/i valid %b%b want 10", d_valid, i_valid); end
    tick();
    vectors++; if (d_valid !== 1'b0) begin miscompares++; $display("FAIL dwrite_pulse: got d_valid %b want 0", d_valid); end
  endtask

  task automatic test_contention();
    logic          exp_d;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    i_read = 1'b1; d_read = 1'b1; i_address = 20'h00020; d_address = 20'h00030;
    for (int k = 0; k < 4; k++) begin
      exp_d    = (k % 2) == 1;
      exp_addr = exp_d ? 20'h00030 : 20'h00020;
      exp_data = 32'h00001000 + k;
      #1;
      vectors++; if ({i_ready, d_ready} !== {~exp_d, exp_d}) begin miscompares++; $display("FAIL contention_grant[%0d]: got i/d ready %b want %b", k, {i_ready, d_ready}, {~exp_d, exp_d}); end
      tick();
      vectors++; if (mem_read !== 1'b1 || mem_address !== exp_addr) begin miscompares++; $display("FAIL contention_issue[%0d]: got rd=%b addr=%h want 1 %h", k, mem_read, mem_address, exp_addr); end
      tick();
      mem_valid = 1'b1; mem_out_data = exp_data; mem_out_addr = exp_addr;
      tick();
      mem_valid = 1'b0;
      vectors++; if ({i_valid, d_valid} !== {~exp_d, exp_d}) begin miscompares++; $display("FAIL contention_route[%0d]: got i/d valid %b want %b", k, {i_valid, d_valid}, {~exp_d, exp_d}); end
      if (exp_d) begin
        vectors++; if (d_out_data !== exp_data || d_out_addr !== exp_addr) begin miscompares++; $display("FAIL contention_ddata[%0d]: got %h@%h want %h@%h", k, d_out_data, d_out_addr, exp_data, exp_addr); end
      end else begin
        vectors++; if (i_out_data !== exp_data || i_out_addr !== exp_addr) begin miscompares++; $display("FAIL contention_idata[%0d]: got %h@%h want %h@%h", k, i_out_data, i_out_addr, exp_data, exp_addr); end
      end
    end
    i_read = 1'b0; d_read = 1'b0;
    tick();
    // Non-owner outputs hold: last I response was k=2, last D was k=3.
    vectors++; if (i_out_data !== 32'h00001002 || d_out_data !== 32'h00001003) begin miscompares++; $display("FAIL contention_hold: got i=%h d=%h want 00001002 00001003", i_out_data, d_out_data); end
  endtask

  task automatic test_backpressure();
    mem_ready = 1'b0; i_read = 1'b1; i_address = 20'h00040;
    for (int k = 0; k < 5; k++) begin
      #1;
      vectors++; if (i_ready !== 1'b0 || mem_read !== 1'b0) begin miscompares++; $display("FAIL backpressure[%0d]: got ready=%b rd=%b want 0 0", k, i_ready, mem_read); end
      tick();
    end
    mem_ready = 1'b1;
    #1;
    vectors++; if (i_ready !== 1'b1) begin miscompares++; $display("FAIL backpressure_release: got i_ready %b want 1", i_ready); end
    tick();
    i_read = 1'b0;
    vectors++; if (mem_read !== 1'b1 || mem_address !== 20'h00040) begin miscompares++; $display("FAIL backpressure_issue: got rd=%b addr=%h want 1 00040", mem_read, mem_address); end
    tick();
    mem_valid = 1'b1; mem_out_data = 32'hCAFE0040; mem_out_addr = 20'h00040;
    tick();
    mem_valid = 1'b0;
    vectors++; if (i_valid !== 1'b1 || i_out_data !== 32'hCAFE0040) begin miscompares++; $display("FAIL backpressure_resp: got valid=%b data=%h want 1 cafe0040", i_valid, i_out_data); end
    tick();
    mem_valid = 1'b1; mem_out_data = 32'hBADBAD00; mem_out_addr = 20'h00099;
    tick();
    mem_valid = 1'b0;
    vectors++; if (i_valid !== 1'b0 || d_valid !== 1'b0) begin miscompares++; $display("FAIL stray_valid: got i/d valid %b%b want 00", i_valid, d_valid); end
    vectors++; if (i_out_data !== 32'hCAFE0040 || mem_read !== 1'b0) begin miscompares++; $display("FAIL stray_hold: got data=%h rd=%b want cafe0040 0", i_out_data, mem_read); end
  endtask

  task automatic test_reset_wait();
    i_read = 1'b1; i_address = 20'h00050;
    #1;
    vectors++; if (i_ready !== 1'b1) begin miscompares++; $display("FAIL rstwait_accept: got i_ready %b want 1", i_ready); end
    tick();
    i_read = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    mem_valid = 1'b1; mem_out_data = 32'h55555555; mem_out_addr = 20'h00050;
    tick();
    reset = 1'b0;
    tick();
    mem_valid = 1'b0;
    vectors++; if (i_valid !== 1'b0 || d_valid !== 1'b0 || i_out_data !== 32'h0) begin miscompares++; $display("FAIL rstwait_drop: got i/d valid %b%b data=%h want 00 0", i_valid, d_valid, i_out_data); end
    i_read = 1'b1; d_read = 1'b1; i_address = 20'h00070; d_address = 20'h00080;
    #1;
    vectors++; if ({i_ready, d_ready} !== 2'b10) begin miscompares++; $display("FAIL rstwait_regrant: got i/d ready %b want 10", {i_ready, d_ready}); end
    tick();
    i_read = 1'b0; d_read = 1'b0;
    vectors++; if (mem_read !== 1'b1 || mem_address !== 20'h00070) begin miscompares++; $display("FAIL rstwait_issue: got rd=%b addr=%h want 1 00070", mem_read, mem_address); end
    tick();
    mem_valid = 1'b1; mem_out_data = 32'h77777777; mem_out_addr = 20'h00070;
    tick();
    mem_valid = 1'b0;
    vectors++; if (i_valid !== 1'b1 || i_out_data !== 32'h77777777) begin miscompares++; $display("FAIL rstwait_resp: got valid=%b data=%h want 1 77777777", i_valid, i_out_data); end
  endtask

  initial begin
    test_reset();
    test_ifetch();
    test_dwrite();
    test_contention();
    test_backpressure();
    test_reset_wait();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
